// File: rtl/mips_cpu_muldiv_if.sv
// Interface bundling the muldiv request/response signals between the EX-stage controller and the unit.
interface mips_cpu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, op_a, op_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, op_a, op_b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO (shift-add multiply, restoring divide).
// Optional build macro MULDIV_FAST_MULT_EN: single-cycle multiplier for MULT/MULTU.
module mips_cpu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  mips_cpu_muldiv_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e               state, state_nxt;
  logic [WIDTH-1:0]     a_reg, b_reg, a_raw;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic                 is_div, neg_q, neg_r, div_zero, done_q;
  logic [WIDTH-1:0]     hi_reg, lo_reg;

  logic                 op_mul, op_div, op_signed, accept, last_iter;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       add_sum, r_shift, r_new;
  logic                 q_bit;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]     q_fix, r_fix, fix_hi, fix_lo;

  always_comb begin
    op_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    accept    = (state == IDLE) && bus.start && !bus.flush && (op_mul || op_div);
    a_abs     = (op_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
    b_abs     = (op_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
    mul_next = {add_sum, acc[WIDTH-1:1]};
    r_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    q_bit    = (r_shift >= {1'b0, b_reg});
    r_new    = q_bit ? (r_shift - {1'b0, b_reg}) : r_shift;
    div_next = {r_new[WIDTH-1:0], acc[WIDTH-2:0], q_bit};
  end

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (div_zero) begin
      fix_hi = a_raw;
      fix_lo = {WIDTH{1'b1}};
    end else begin
      fix_hi = r_fix;
      fix_lo = q_fix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef MULDIV_FAST_MULT_EN
          state_nxt = op_mul ? FIX : RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN:     if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      a_raw    <= '0;
      acc      <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      done_q   <= 1'b0;
      hi_reg   <= '0;
      lo_reg   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg    <= a_abs;
            b_reg    <= b_abs;
            a_raw    <= bus.op_a;
            cnt      <= '0;
            is_div   <= op_div;
            neg_q    <= op_signed && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            neg_r    <= op_signed && bus.op_a[WIDTH-1];
            div_zero <= op_div && (bus.op_b == '0);
`ifdef MULDIV_FAST_MULT_EN
            acc      <= op_mul ? ({{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs})
                               : {{WIDTH{1'b0}}, a_abs};
`else
            acc      <= {{WIDTH{1'b0}}, (op_div ? a_abs : b_abs)};
`endif
          end else if (bus.start && !bus.flush && (bus.op == OP_MTHI)) begin
            hi_reg <= bus.op_a;
          end else if (bus.start && !bus.flush && (bus.op == OP_MTLO)) begin
            lo_reg <= bus.op_a;
          end
        end
        RUN: begin
          if (!bus.flush) begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          if (!bus.flush) begin
            hi_reg <= fix_hi;
            lo_reg <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = done_q;
    bus.hi   = hi_reg;
    bus.lo   = lo_reg;
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed self-checking bench for mips_cpu_muldiv; honours MULDIV_FAST_MULT_EN for multiply timing.
module tb_mips_cpu_muldiv;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mips_cpu_muldiv_if #(.WIDTH(32)) bus ();

  mips_cpu_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one op, scrambles operands after accept, and watches up to 40 edges.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int done_edge, output int busy_n, output int done_n,
                        output bit partial);
    logic [31:0] h0, l0;
    h0 = bus.hi;
    l0 = bus.lo;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.op_a = a; bus.op_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'b000; bus.op_a = 32'hDEADBEEF; bus.op_b = 32'h0BADF00D;
    done_edge = -1; busy_n = 0; done_n = 0; partial = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_edge < 0) done_edge = k;
      end
      if (done_edge < 0 && (bus.hi !== h0 || bus.lo !== l0)) partial = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 3'b000; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 00000000", bus.lo); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b101; bus.op_a = 32'hA5A5A5A5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++; if (bus.hi !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL pre_reset_mthi: got %h expected a5a5a5a5", bus.hi); end
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b001; bus.op_a = 32'hFFFFFFFE; bus.op_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrun_reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL midrun_reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL midrun_reset_hi: got %h expected 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL midrun_reset_lo: got %h expected 00000000", bus.lo); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int de, bn, dn;
    bit pt;
    run_op(3'b001, 32'hFFFFFFFE, 32'd3, de, bn, dn, pt);
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFA) begin errors++; $display("[TB] FAIL mult_lo: got %h expected fffffffa", bus.lo); end
    checks++; if (de !== MUL_LAT) begin errors++; $display("[TB] FAIL mult_done_latency: got %0d expected %0d", de, MUL_LAT); end
    checks++; if (bn !== MUL_LAT) begin errors++; $display("[TB] FAIL mult_busy_cycles: got %0d expected %0d", bn, MUL_LAT); end
    checks++; if (dn !== 1) begin errors++; $display("[TB] FAIL mult_done_pulses: got %0d expected 1", dn); end
    checks++; if (pt !== 1'b0) begin errors++; $display("[TB] FAIL mult_partial_visible: got %b expected 0", pt); end
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, de, bn, dn, pt);
    checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL multu_hi: got %h expected fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("[TB] FAIL multu_lo: got %h expected 00000001", bus.lo); end
    checks++; if (de !== MUL_LAT) begin errors++; $display("[TB] FAIL multu_done_latency: got %0d expected %0d", de, MUL_LAT); end
    run_op(3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, de, bn, dn, pt);
    checks++; if (bus.hi !== 32'h3FFFFFFF) begin errors++; $display("[TB] FAIL mult_max_hi: got %h expected 3fffffff", bus.hi); end
    checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("[TB] FAIL mult_max_lo: got %h expected 00000001", bus.lo); end
  endtask

  task automatic test_div;
    int de, bn, dn;
    bit pt;
    run_op(3'b011, 32'hFFFFFFF9, 32'd2, de, bn, dn, pt);
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_lo: got %h expected fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_hi: got %h expected ffffffff", bus.hi); end
    checks++; if (de !== DIV_LAT) begin errors++; $display("[TB] FAIL div_done_latency: got %0d expected %0d", de, DIV_LAT); end
    checks++; if (bn !== DIV_LAT) begin errors++; $display("[TB] FAIL div_busy_cycles: got %0d expected %0d", bn, DIV_LAT); end
    checks++; if (pt !== 1'b0) begin errors++; $display("[TB] FAIL div_partial_visible: got %b expected 0", pt); end
    run_op(3'b011, 32'd100, 32'hFFFFFFF9, de, bn, dn, pt);
    checks++; if (bus.lo !== 32'hFFFFFFF2) begin errors++; $display("[TB] FAIL div_negdivisor_lo: got %h expected fffffff2", bus.lo); end
    checks++; if (bus.hi !== 32'h00000002) begin errors++; $display("[TB] FAIL div_negdivisor_hi: got %h expected 00000002", bus.hi); end
    run_op(3'b100, 32'd7, 32'd0, de, bn, dn, pt);
    checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL divu_zero_lo: got %h expected ffffffff", bus.lo); end
    checks++; if (bus.hi !== 32'h00000007) begin errors++; $display("[TB] FAIL divu_zero_hi: got %h expected 00000007", bus.hi); end
    checks++; if (de !== DIV_LAT) begin errors++; $display("[TB] FAIL divu_zero_latency: got %0d expected %0d", de, DIV_LAT); end
    run_op(3'b011, 32'h80000000, 32'hFFFFFFFF, de, bn, dn, pt);
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("[TB] FAIL div_overflow_lo: got %h expected 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h00000000) begin errors++; $display("[TB] FAIL div_overflow_hi: got %h expected 00000000", bus.hi); end
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b101; bus.op_a = 32'h12345678;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'b000;
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("[TB] FAIL mthi_hi: got %h expected 12345678", bus.hi); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mthi_busy: got %b expected 0", bus.busy); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL mthi_done: got %b expected 0", bus.done); end
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b110; bus.op_a = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'b000;
    checks++; if (bus.lo !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL mtlo_lo: got %h expected cafef00d", bus.lo); end
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("[TB] FAIL mtlo_hi_kept: got %h expected 12345678", bus.hi); end
  endtask

  task automatic test_back_to_back;
    int de;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.op_a = 32'd6; bus.op_b = 32'd7;
    @(posedge clk); #1;
    bus.op = 3'b100; bus.op_a = 32'd100; bus.op_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'b000;
    de = -1;
    for (int k = 1; k <= 40 && de < 0; k++) begin
      if (bus.done) de = k;
      else begin @(posedge clk); #1; end
    end
    checks++; if (de !== MUL_LAT) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d expected %0d", de, MUL_LAT); end
    checks++; if (bus.lo !== 32'd42) begin errors++; $display("[TB] FAIL b2b_first_lo: got %h expected 0000002a", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("[TB] FAIL b2b_first_hi: got %h expected 00000000", bus.hi); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_not_queued: got %b expected 0", bus.busy); end
    bus.start = 1'b1; bus.op = 3'b100; bus.op_a = 32'd100; bus.op_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'b000;
    de = -1;
    for (int k = 0; k <= 40 && de < 0; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (bus.done) de = k;
    end
    checks++; if (de !== DIV_LAT) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", de, DIV_LAT); end
    checks++; if (bus.lo !== 32'd33) begin errors++; $display("[TB] FAIL b2b_second_lo: got %h expected 00000021", bus.lo); end
    checks++; if (bus.hi !== 32'd1) begin errors++; $display("[TB] FAIL b2b_second_hi: got %h expected 00000001", bus.hi); end
  endtask

  task automatic test_flush;
    int dn;
    logic [31:0] h0, l0;
    h0 = bus.hi; l0 = bus.lo;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b011; bus.op_a = 32'd1000; bus.op_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'b000;
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_run_busy: got %b expected 0", bus.busy); end
    dn = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (bus.done) dn++; end
    checks++; if (dn !== 0) begin errors++; $display("[TB] FAIL flush_run_done: got %0d pulses expected 0", dn); end
    checks++; if (bus.hi !== h0) begin errors++; $display("[TB] FAIL flush_run_hi: got %h expected %h", bus.hi, h0); end
    checks++; if (bus.lo !== l0) begin errors++; $display("[TB] FAIL flush_run_lo: got %h expected %h", bus.lo, l0); end
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b001; bus.op_a = 32'd5; bus.op_b = 32'd5; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'b000; bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_start_busy: got %b expected 0", bus.busy); end
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b100; bus.op_a = 32'd50; bus.op_b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'b000;
    repeat (32) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    dn = 0;
    for (int k = 0; k < 5; k++) begin if (bus.done) dn++; @(posedge clk); #1; end
    checks++; if (dn !== 0) begin errors++; $display("[TB] FAIL flush_fix_done: got %0d pulses expected 0", dn); end
    checks++; if (bus.hi !== h0) begin errors++; $display("[TB] FAIL flush_fix_hi: got %h expected %h", bus.hi, h0); end
    checks++; if (bus.lo !== l0) begin errors++; $display("[TB] FAIL flush_fix_lo: got %h expected %h", bus.lo, l0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_back_to_back();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
